// File: rtl/mux2to1_arbiter.sv
// mux2to1_arbiter: two-requester arbiter with a shared 2:1 data mux.
// Fairness comes from last-served priority and a per-grant transfer budget.
module mux2to1_arbiter #(
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic [WIDTH-1:0] data0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data1,
  input  logic             out_ready,
  output logic             gnt0,
  output logic             gnt1,
  output logic             sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);
  localparam logic [1:0] IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2;
  localparam logic [3:0] MAXH = 4'(MAX_HOLD);
  logic [1:0] state, nxt;
  logic [3:0] hold, hold_inc;
  logic       last_srv, xfer;
  assign gnt0      = state == OWN0;
  assign gnt1      = state == OWN1;
  assign out_valid = (gnt0 & req0) | (gnt1 & req1);
  assign out_data  = sel ? data1 : data0;
  assign xfer      = out_valid & out_ready;
  // the budget check uses the count including this cycle's transfer
  always_comb hold_inc = (xfer && hold != MAXH) ? hold + 4'd1 : hold;
  always_comb
    nxt = state == IDLE ? ((req0 && req1) ? (last_srv ? OWN0 : OWN1) : req0 ? OWN0 : req1 ? OWN1 : IDLE)
        : state == OWN0 ? (!req0 ? (req1 ? OWN1 : IDLE) : (req1 && hold_inc == MAXH) ? OWN1 : OWN0)
        : state == OWN1 ? (!req1 ? (req0 ? OWN0 : IDLE) : (req0 && hold_inc == MAXH) ? OWN0 : OWN1)
        : IDLE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= IDLE;
      hold     <= 4'd0;
      sel      <= 1'b0;
      last_srv <= 1'b1;
    end else begin
      state    <= nxt;
      hold     <= (nxt != state) ? 4'd0 : hold_inc;
      sel      <= (nxt == OWN1) ? 1'b1 : (nxt == OWN0) ? 1'b0 : sel;
      last_srv <= xfer ? gnt1 : last_srv;
    end
endmodule

// File: tb/tb_mux2to1_arbiter.sv
// tb_mux2to1_arbiter: directed checks of grant sequencing, hold budget and reset.
module tb_mux2to1_arbiter;
  logic       clk = 1'b0;
  logic       rst_n, req0, req1, out_ready;
  logic [7:0] data0, data1;
  logic       gnt0, gnt1, sel, out_valid;
  logic [7:0] out_data;
  int checks = 0;
  int errors = 0;

  mux2to1_arbiter #(.WIDTH(8), .MAX_HOLD(4)) dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .data0(data0), .req1(req1), .data1(data1),
    .out_ready(out_ready), .gnt0(gnt0), .gnt1(gnt1), .sel(sel),
    .out_valid(out_valid), .out_data(out_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; out_ready = 1'b0; data0 = 8'h00; data1 = 8'h00;
    #3;
    chk("rst_gnt0", gnt0, 0); chk("rst_gnt1", gnt1, 0);
    chk("rst_sel", sel, 0); chk("rst_valid", out_valid, 0);
    #9;
    rst_n = 1'b1; req0 = 1'b1; data0 = 8'hA5; out_ready = 1'b1;
    #1;
    chk("release_no_gnt", gnt0, 0); chk("release_no_valid", out_valid, 0);
    cyc();
    chk("first_gnt0", gnt0, 1); chk("first_sel", sel, 0);
    chk("first_valid", out_valid, 1); chk("first_data", out_data, 8'hA5);
    // ten transfers with no competitor: grant and select must stay put
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("sat_gnt0", gnt0, 1); chk("sat_sel", sel, 0);
    end
    req1 = 1'b1;
    cyc();
    chk("sat_switch_gnt1", gnt1, 1); chk("sat_switch_gnt0", gnt0, 0); chk("sat_switch_sel", sel, 1);
    out_ready = 1'b0; data1 = 8'h3C;
    #1;
    chk("own1_data", out_data, 8'h3C); chk("own1_valid", out_valid, 1);
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("stall_gnt1", gnt1, 1);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("budget_gnt1", gnt1, 1);
    end
    cyc();
    chk("budget_gnt0", gnt0, 1); chk("budget_sel", sel, 0);
    out_ready = 1'b0; req0 = 1'b0;
    cyc();
    chk("drop_gnt1", gnt1, 1); chk("drop_gnt0", gnt0, 0); chk("drop_sel", sel, 1);
    out_ready = 1'b1;
    cyc();
    chk("burst1_gnt1", gnt1, 1);
    cyc();
    chk("burst2_gnt1", gnt1, 1);
    req0 = 1'b1; rst_n = 1'b0;
    #1;
    chk("abort_gnt1", gnt1, 0); chk("abort_sel", sel, 0); chk("abort_valid", out_valid, 0);
    cyc();
    chk("inrst_gnt0", gnt0, 0); chk("inrst_gnt1", gnt1, 0);
    rst_n = 1'b1;
    cyc();
    chk("post_rst_gnt0", gnt0, 1); chk("post_rst_sel", sel, 0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("rr_gnt0", gnt0, 1);
    end
    cyc();
    chk("rr_gnt1", gnt1, 1); chk("rr_sel1", sel, 1);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("rr_hold_gnt1", gnt1, 1);
    end
    cyc();
    chk("rr_back_gnt0", gnt0, 1); chk("rr_back_sel", sel, 0);
    req0 = 1'b0;
    cyc();
    chk("req1_only_gnt1", gnt1, 1);
    req1 = 1'b0;
    cyc();
    chk("idle_gnt0", gnt0, 0); chk("idle_gnt1", gnt1, 0);
    chk("idle_sel_held", sel, 1); chk("idle_valid", out_valid, 0);
    req0 = 1'b1; req1 = 1'b1;
    cyc();
    chk("idle_both_gnt0", gnt0, 1); chk("idle_both_sel", sel, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
